// File: rtl/saw_pkg.sv
// rtl/saw_pkg.sv - shared widths and state encoding for the sawtooth oscillator and meter
package saw_pkg;

  localparam int FRAC_BITS = 24;
  localparam int INT_BITS  = 8;
  localparam int MAX_DELTA = 256;
  localparam int FREQ_W    = 32;
  localparam int SAMPLE_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    MEASURE,
    FINAL,
    DONE
  } saw_state_e;

endpackage

// File: rtl/saw_delta.sv
// rtl/saw_delta.sv - modulo-2^16 sample difference with clamp to MAX_DELTA
module saw_delta
  import saw_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [SAMPLE_W-1:0] prev_i,
  output logic [8:0]          delta_clamped,
  output logic                over
);

  logic [SAMPLE_W-1:0] diff;

  // Unsigned wrap-around subtraction covers the 0xFFFF -> 0x0000 rollover.
  always_comb begin
    diff          = sample_i - prev_i;
    over          = diff > SAMPLE_W'(MAX_DELTA);
    delta_clamped = over ? 9'(MAX_DELTA) : diff[8:0];
  end

endmodule

// File: rtl/saw_freq_meter.sv
// rtl/saw_freq_meter.sv - recovers the 8.24 frequency word from a sawtooth sample stream
module saw_freq_meter
  import saw_pkg::*;
#(
  parameter int GATE_LOG2 = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [SAMPLE_W-1:0] SAW,
  input  logic                SAW_VALID,
  input  logic                START,
  output logic                BUSY,
  output logic [FREQ_W-1:0]   FREQ_OUT,
  output logic                FREQ_VALID,
  input  logic                FREQ_READY,
  output logic                OVERRANGE
);

  localparam int ACC_W = GATE_LOG2 + INT_BITS + 1;
  localparam int CNT_W = GATE_LOG2 + 1;
  localparam int SHIFT = FRAC_BITS - GATE_LOG2;

  saw_state_e          state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [SAMPLE_W-1:0] prev_q;
  logic                over_q;
  logic                busy_q;
  logic                valid_q;
  logic                ovr_out_q;
  logic [FREQ_W-1:0]   freq_q;

  logic [8:0]          delta_clamped;
  logic                delta_over;
  logic [FREQ_W:0]     sum_scaled;

  saw_delta u_delta (
    .sample_i      (SAW),
    .prev_i        (prev_q),
    .delta_clamped (delta_clamped),
    .over          (delta_over)
  );

  // The scaled sum is always 33 bits wide; its top bit is set exactly when sum >= 2^(GATE_LOG2+8).
  always_comb begin
    acc_d      = acc_q + ACC_W'(delta_clamped);
    cnt_d      = cnt_q + CNT_W'(1);
    sum_scaled = (FREQ_W + 1)'(acc_q) << SHIFT;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      over_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovr_out_q <= 1'b0;
      freq_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q <= PRIME;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            over_q  <= 1'b0;
          end
        end
        PRIME: begin
          if (SAW_VALID) begin
            prev_q  <= SAW;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (SAW_VALID) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            prev_q <= SAW;
            over_q <= over_q | delta_over;
            if (cnt_d[GATE_LOG2]) begin
              state_q <= FINAL;
            end
          end
        end
        FINAL: begin
          if (sum_scaled[FREQ_W]) begin
            freq_q    <= '1;
            ovr_out_q <= 1'b1;
          end else begin
            freq_q    <= sum_scaled[FREQ_W-1:0];
            ovr_out_q <= over_q;
          end
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          if (FREQ_READY) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY       = busy_q;
  assign FREQ_OUT   = freq_q;
  assign FREQ_VALID = valid_q;
  assign OVERRANGE  = ovr_out_q;

endmodule

// File: doc/saw_freq_meter.md
Name: saw_freq_meter

Overview:
- Inverse of the sawtooth phase-accumulator generator: observes the 16-bit sawtooth sample stream and recovers the 32-bit 8.24 frequency word (8-bit integer increment, 24-bit fraction per clock) that produced it.
- Sums modulo-2^16 sample-to-sample deltas over a gate of 2^GATE_LOG2 valid samples, then scales the sum to 8.24.
- Sits beside the oscillator for self-test and calibration; the result is delivered on a valid/ready handshake.

Parameters:
GATE_LOG2, 16, log2 of the number of deltas per measurement; legal range 1..24.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST_N  in  1  reset, synchronous, active-low.
SAW  in  16  sawtooth sample from the oscillator.
SAW_VALID  in  1  SAW is a new sample this cycle (tie to oscillator LOCKED).
START  in  1  single-cycle request to begin a measurement.
BUSY  out  1  high in PRIME, MEASURE and FINAL.
FREQ_OUT  out  32  measured 8.24 frequency word.
FREQ_VALID  out  1  FREQ_OUT valid; held until accepted.
FREQ_READY  in  1  consumer accepts FREQ_OUT when FREQ_VALID && FREQ_READY.
OVERRANGE  out  1  qualifies FREQ_OUT: a delta exceeded 256, or the sum saturated.

Behaviour:
- Reset (RST_N low at an edge): state IDLE; BUSY=0, FREQ_VALID=0, FREQ_OUT=0, OVERRANGE=0; accumulator, sample counter and previous-sample register cleared. Reset applied mid-measurement aborts it with no output.
- States: IDLE, PRIME, MEASURE, FINAL, DONE.
- IDLE: START=1 -> PRIME; clear accumulator, counter and overrange flag.
- PRIME: on the first SAW_VALID=1 cycle, latch SAW into prev -> MEASURE.
- MEASURE, each SAW_VALID=1 cycle:
  - delta = (SAW - prev) mod 2^16, 16-bit unsigned;
  - if delta > 256, set the sticky overrange flag and add 256 instead;
  - add delta to the accumulator; prev <= SAW; counter++;
  - when the counter reaches 2^GATE_LOG2 -> FINAL.
- SAW_VALID=0 in PRIME or MEASURE pauses the block: no capture, no accumulate, no count.
- Accumulator width: GATE_LOG2+9 bits. Counter width: GATE_LOG2+1 bits.
- FINAL (one cycle): if sum >= 2^(GATE_LOG2+8), FREQ_OUT=32'hFFFFFFFF and OVERRANGE=1; otherwise FREQ_OUT = sum << (24-GATE_LOG2), truncated to 32 bits, and OVERRANGE = sticky flag. Set FREQ_VALID=1 -> DONE.
- DONE: FREQ_OUT, OVERRANGE and FREQ_VALID held stable. FREQ_VALID && FREQ_READY at an edge -> IDLE with FREQ_VALID=0; FREQ_OUT keeps its last value.
- START is ignored outside IDLE, including in DONE. START on the same edge as acceptance is ignored; a new START is needed in IDLE.
- Latency with SAW_VALID continuously high: START at edge 0; PRIME capture at edge 1; deltas at edges 2..2^G+1; FREQ_VALID high after edge 2^G+2.
- BUSY is registered and equals (state in PRIME, MEASURE or FINAL).
- SAW wrap 0xFFFF->0x0000 is handled by the modulo subtraction; no special case.
- Zero-frequency input (SAW constant) gives FREQ_OUT=0, OVERRANGE=0.

Decomposition:
- Shared package saw_pkg:
  - state enum {IDLE, PRIME, MEASURE, FINAL, DONE};
  - FRAC_BITS=24, INT_BITS=8, MAX_DELTA=256;
  - FREQ_W=32, SAMPLE_W=16.
  - The oscillator uses the same width constants.
- One sub-module, saw_delta: combinational modulo-2^16 difference and range clamp. Outputs delta_clamped[8:0] and over.

Test Plan:
- GATE_LOG2=8, ideal phase accumulator with word 0x01000000 feeding SAW, START -> after 258 cycles FREQ_OUT=0x01000000, OVERRANGE=0.
- GATE_LOG2=8, word 0x00800000 (half step) -> FREQ_OUT=0x00800000. Word 0x2A400000 -> FREQ_OUT=0x2A400000.
- Constant delta 0x30 starting at SAW=0xFFF0, wrapping through 0x0000 -> FREQ_OUT=0x30000000, no OVERRANGE.
- One sample jumps by 0x0200 mid-gate, others delta 1 -> OVERRANGE=1 with FREQ_VALID.
- Hold FREQ_READY=0 for 20 cycles after FREQ_VALID, pulse START meanwhile -> FREQ_OUT stable, START ignored. FREQ_READY=1 -> IDLE next edge.
- Drop SAW_VALID for 10 cycles mid-gate (SAW held), then drop RST_N during MEASURE -> pause adds 10 cycles and the result is unchanged; reset returns to IDLE with all outputs 0.
